// File: rtl/uart_alu_if.sv
// UART<->ALU bridge: assembles A, B (NB bytes each, LSB first) and an opcode from RX bytes,
// latches the ALU result and sends it back byte by byte. Optional inter-byte timeout: UART_IF_TIMEOUT_EN.
module uart_alu_if #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_tx_done,
  output logic [DATA_W-1:0] o_datoA,
  output logic [DATA_W-1:0] o_datoB,
  output logic [OP_W-1:0]   o_opcode,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, LATCH, TX_START, TX_WAIT} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shadow, shadow_nx, result;
  logic              rx_state, last_byte, abort;

  assign rx_state  = (state == RX_A) || (state == RX_B) || (state == RX_OP);
  assign last_byte = (idx == IDX_LAST);

`ifdef UART_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] gap_cnt;
  logic             started;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign abort = rx_state && started && !i_rx_done && (gap_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt       <= '0;
      started       <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_timeout_err <= abort;
      if (!rx_state || abort) begin
        gap_cnt <= '0;
        started <= 1'b0;
      end else if (i_rx_done) begin
        gap_cnt <= '0;
        started <= 1'b1;
      end else if (started) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end
`else
  assign abort         = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_comb begin
    shadow_nx = shadow;
    shadow_nx[idx*8 +: 8] = i_rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_A;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RX_A:     if (abort) state_nx = RX_A;
                else if (i_rx_done && last_byte) state_nx = RX_B;
      RX_B:     if (abort) state_nx = RX_A;
                else if (i_rx_done && last_byte) state_nx = RX_OP;
      RX_OP:    if (abort) state_nx = RX_A;
                else if (i_rx_done) state_nx = LATCH;
      LATCH:    state_nx = TX_START;
      TX_START: state_nx = TX_WAIT;
      TX_WAIT:  if (i_tx_done) state_nx = last_byte ? RX_A : TX_START;
      default:  state_nx = RX_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      shadow   <= '0;
      result   <= '0;
      o_datoA  <= '0;
      o_datoB  <= '0;
      o_opcode <= '0;
    end else begin
      case (state)
        RX_A, RX_B: begin
          if (abort) begin
            idx    <= '0;
            shadow <= '0;
          end else if (i_rx_done) begin
            shadow <= shadow_nx;
            if (last_byte) begin
              idx <= '0;
              if (state == RX_A) o_datoA <= shadow_nx;
              else               o_datoB <= shadow_nx;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RX_OP: begin
          if (abort) begin
            idx    <= '0;
            shadow <= '0;
          end else if (i_rx_done) begin
            o_opcode <= i_rx_data[OP_W-1:0];
          end
        end
        LATCH:   result <= i_alu_result;
        TX_WAIT: if (i_tx_done) idx <= last_byte ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  // idx is frozen from TX_START until i_tx_done, so the byte stays stable.
  assign o_tx_data  = result[idx*8 +: 8];
  assign o_tx_start = (state == TX_START);
  assign o_busy     = (state == LATCH) || (state == TX_START) || (state == TX_WAIT);

endmodule
